// File: rtl/uibi_pkg.sv
// Shared definitions for the uibi interconnect: size codes, FSM states and
// small helpers for lane count, access byte size and size-code legality.
package uibi_pkg;

   localparam logic [2:0] BUS_FULL = 3'b111;
   localparam logic [2:0] BUS_HALF = 3'b011;
   localparam logic [2:0] BUS_QUAR = 3'b001;
   localparam logic [2:0] BUS_NULL = 3'b000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } uibi_state_t;

   function automatic int lane_count(input int xlen);
      return xlen / 8;
   endfunction

   // Bytes moved by one access of the given size code; 0 for null/illegal.
   function automatic int mode_bytes(input logic [2:0] mode, input int lanes);
      int nbytes;
      case (mode)
         BUS_FULL: nbytes = lanes;
         BUS_HALF: nbytes = lanes / 2;
         BUS_QUAR: nbytes = lanes / 4;
         default:  nbytes = 0;
      endcase
      return nbytes;
   endfunction

   function automatic logic mode_legal(input logic [2:0] mode);
      return (mode == BUS_FULL) || (mode == BUS_HALF) ||
             (mode == BUS_QUAR) || (mode == BUS_NULL);
   endfunction

endpackage

// File: rtl/uibi_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester found when
// searching upward (with wrap) from ptr gets a one-hot grant and index.
module uibi_rr_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int IW          = 1
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [IW-1:0]          ptr,
   output logic [NUM_MASTERS-1:0] grant,
   output logic [IW-1:0]          idx,
   output logic                   any
);

   int j;

   // Scan from farthest to nearest so the requester closest to ptr wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % NUM_MASTERS;
         if (req[j]) begin
            grant    = '0;
            grant[j] = 1'b1;
            idx      = IW'(j);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uibi_interconnect.sv
// Multi-master internal-bus interconnect: round-robin arbitration onto one
// shared slave path, byte-lane strobes, error response for bad accesses.
// Optional slave-wait timeout enabled by defining UIBI_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | arbitrate, latch winner's fields, decode legality
// ACCESS | s_req held to selected slave until its s_ready (or timeout)
// RESP   | one-cycle m_ready pulse to granted master, advance RR pointer
module uibi_interconnect
   import uibi_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int SLAVE_WIDTH    = 2,
   parameter int NUM_MASTERS    = 2,
   parameter int NUM_SLAVES     = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [NUM_MASTERS-1:0]                    m_req,
   input  logic [NUM_MASTERS-1:0]                    m_wen,
   input  logic [NUM_MASTERS*SLAVE_WIDTH-1:0]        m_num,
   input  logic [NUM_MASTERS*(XLEN-SLAVE_WIDTH)-1:0] m_addr,
   input  logic [NUM_MASTERS*3-1:0]                  m_mode,
   input  logic [NUM_MASTERS*XLEN-1:0]               m_wdata,
   output logic [XLEN-1:0]                           m_rdata,
   output logic [NUM_MASTERS-1:0]                    m_ready,
   output logic [NUM_MASTERS-1:0]                    m_err,
   output logic [NUM_SLAVES-1:0]                     s_req,
   output logic                                      s_wen,
   output logic [XLEN-SLAVE_WIDTH-1:0]               s_addr,
   output logic [2:0]                                s_mode,
   output logic [XLEN/8-1:0]                         s_strb,
   output logic [XLEN-1:0]                           s_wdata,
   input  logic [NUM_SLAVES*XLEN-1:0]                s_rdata,
   input  logic [NUM_SLAVES-1:0]                     s_ready
);

   localparam int AW    = XLEN - SLAVE_WIDTH;
   localparam int LANES = lane_count(XLEN);
   localparam int LW    = $clog2(LANES);
   localparam int IW    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   if ((XLEN % 32 != 0) || (NUM_MASTERS < 1) || (NUM_SLAVES > 2**SLAVE_WIDTH) ||
       (TIMEOUT_CYCLES < 1)) begin : g_param_check
      $error("uibi_interconnect: illegal parameter combination");
   end

   uibi_state_t             state_q, state_d;
   logic [IW-1:0]           ptr_q, gnt_q;
   logic [SLAVE_WIDTH-1:0]  sel_q;
   logic                    err_q;
   logic [XLEN-1:0]         rdata_q;

   logic [NUM_MASTERS-1:0]  gnt_oh;
   logic [IW-1:0]           gnt_idx;
   logic                    gnt_any;

   logic                    w_wen;
   logic [SLAVE_WIDTH-1:0]  w_num;
   logic [AW-1:0]           w_addr;
   logic [2:0]              w_mode;
   logic [XLEN-1:0]         w_wdata;
   int                      w_bytes, w_shift;
   logic [LW-1:0]           w_low, w_szm;
   logic                    w_misal, w_bad;
   logic [LANES-1:0]        w_strb;
   logic [XLEN-1:0]         w_wdata_m;
   logic [NUM_SLAVES-1:0]   w_sreq;

   logic                    sel_ready;
   logic [XLEN-1:0]         sel_rdata, strb_mask;
   logic                    tmo_hit;

   uibi_rr_arbiter #(.NUM_MASTERS(NUM_MASTERS), .IW(IW)) u_arb (
      .req   (m_req),
      .ptr   (ptr_q),
      .grant (gnt_oh),
      .idx   (gnt_idx),
      .any   (gnt_any)
   );

   // Select the winning master's request fields.
   always_comb begin
      w_wen   = 1'b0;
      w_num   = '0;
      w_addr  = '0;
      w_mode  = '0;
      w_wdata = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (gnt_oh[i]) begin
            w_wen   = m_wen[i];
            w_num   = m_num[i*SLAVE_WIDTH +: SLAVE_WIDTH];
            w_addr  = m_addr[i*AW +: AW];
            w_mode  = m_mode[i*3 +: 3];
            w_wdata = m_wdata[i*XLEN +: XLEN];
         end
      end
   end

   // Legality, lane strobe, masked write data and slave one-hot for the winner.
   always_comb begin
      w_bytes = mode_bytes(w_mode, LANES);
      w_low   = w_addr[LW-1:0];
      w_szm   = (w_bytes == 0) ? '0 : LW'(w_bytes - 1);
      w_misal = |(w_low & w_szm);
      w_shift = int'(w_low & ~w_szm);
      w_bad   = (int'(w_num) >= NUM_SLAVES) || !mode_legal(w_mode) || w_misal;
      w_strb    = '0;
      w_wdata_m = '0;
      for (int b = 0; b < LANES; b++) begin
         w_strb[b] = (b >= w_shift) && (b < w_shift + w_bytes);
         w_wdata_m[b*8 +: 8] = w_strb[b] ? w_wdata[b*8 +: 8] : 8'h00;
      end
      w_sreq = '0;
      for (int s = 0; s < NUM_SLAVES; s++) begin
         w_sreq[s] = (w_num == SLAVE_WIDTH'(s));
      end
   end

   // Response path from the slave selected for the current access.
   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      strb_mask = '0;
      for (int s = 0; s < NUM_SLAVES; s++) begin
         if (sel_q == SLAVE_WIDTH'(s)) begin
            sel_ready = s_ready[s];
            sel_rdata = s_rdata[s*XLEN +: XLEN];
         end
      end
      for (int b = 0; b < LANES; b++) begin
         strb_mask[b*8 +: 8] = {8{s_strb[b]}};
      end
   end

`ifdef UIBI_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt_q;

   assign tmo_hit = (state_q == ST_ACCESS) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

   // Count ACCESS cycles; held at zero outside ACCESS so each entry starts fresh.
   always_ff @(posedge clk) begin
      if (!rst_n)                  tmo_cnt_q <= '0;
      else if (state_q != ST_ACCESS) tmo_cnt_q <= '0;
      else                         tmo_cnt_q <= tmo_cnt_q + 1'b1;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_any) begin
               state_d = (w_bad || (w_mode == BUS_NULL)) ? ST_RESP : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (sel_ready || tmo_hit) state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register and registered slave-side datapath.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         sel_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         s_req   <= '0;
         s_wen   <= 1'b0;
         s_addr  <= '0;
         s_mode  <= '0;
         s_strb  <= '0;
         s_wdata <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (gnt_any) begin
                  gnt_q   <= gnt_idx;
                  sel_q   <= w_num;
                  s_wen   <= w_wen;
                  s_addr  <= w_addr;
                  s_mode  <= w_mode;
                  s_strb  <= w_strb;
                  s_wdata <= w_wdata_m;
                  err_q   <= w_bad;
                  rdata_q <= '0;
                  if (!w_bad && (w_mode != BUS_NULL)) s_req <= w_sreq;
               end
            end
            ST_ACCESS: begin
               if (sel_ready) begin
                  s_req   <= '0;
                  rdata_q <= sel_rdata & strb_mask;
                  err_q   <= 1'b0;
               end else if (tmo_hit) begin
                  s_req   <= '0;
                  rdata_q <= '0;
                  err_q   <= 1'b1;
               end
            end
            ST_RESP: begin
               ptr_q <= (gnt_q == IW'(NUM_MASTERS - 1)) ? '0 : gnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Master-side response is visible only during RESP.
   always_comb begin
      m_ready = '0;
      m_err   = '0;
      m_rdata = '0;
      if (state_q == ST_RESP) begin
         m_rdata = rdata_q;
         for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gnt_q == IW'(i)) begin
               m_ready[i] = 1'b1;
               m_err[i]   = err_q;
            end
         end
      end
   end

endmodule
